serial_subtractor_4bit: RTL and testbench

Bit-serial ripple-borrow subtractor: computes A − B − Bin one bit per clock, least-significant bit first, through a single registered full-subtractor cell. It is the subtracting counterpart of the team's registered 4-bit full adder and sits beside it in the arithmetic datapath. Operands and results move over valid/ready handshakes, so upstream and downstream logic can stall freely.

---
 rtl/sub_pkg.sv | 17 +
 rtl/full_subtractor_1bit.sv | 13 +
 rtl/serial_subtractor_4bit.sv | 123 ++++++++++++
 tb/tb_serial_subtractor_4bit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SUB_WIDTH = 4;

  // One spare bit so the index can count through WIDTH without wrapping.
  function automatic int idx_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor_1bit.sv
// rtl/full_subtractor_1bit.sv - combinational one-bit full subtractor cell
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// rtl/serial_subtractor_4bit.sv - bit-serial A - B - Bin, LSB first, valid/ready on both sides
module serial_subtractor_4bit
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Diff,
  output logic             Bout
);

  localparam int IW = idx_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             out_valid_q, out_valid_d;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH:0]   res_shift;

  full_subtractor_1bit u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift = {cell_d, res_q};

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    br_d        = br_q;
    idx_d       = idx_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = A;
          b_sh_d  = B;
          br_d    = Bin;
          idx_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = cell_bout;
        res_d  = res_shift[WIDTH:1];
        idx_d  = idx_q + IW'(1);
        if (idx_q == IW'(WIDTH - 1)) begin
          diff_d      = {cell_bout, res_shift[WIDTH:1]};
          bout_d      = cell_bout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      br_q        <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      br_q        <= br_d;
      idx_q       <= idx_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// tb/tb_serial_subtractor_4bit.sv - self-checking bench for serial_subtractor_4bit
module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   Diff;
  logic         Bout;

  int tests = 0;
  int fails = 0;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_diff(input int a, input int b, input int bin);
    int r;
    r = (a - b - bin) % 32;
    if (r < 0) r += 32;
    return r[W:0];
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bin);
    return (a < b + bin);
  endfunction

  task automatic accept(input int a, input int b, input int bin);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", in_ready, 1);
    A = a[W-1:0];
    B = b[W-1:0];
    Bin = bin[0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    Bin = $urandom;
  endtask

  task automatic wait_result(input string tag, input int a, input int b, input int bin);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, W);
    check({tag, "_diff"}, Diff, ref_diff(a, b, bin));
    check({tag, "_bout"}, Bout, ref_bout(a, b, bin));
  endtask

  initial begin
    int sent;
    int got;
    int cyc;
    int seen_valid;
    logic [8:0] code;
    logic [W:0] q_diff[$];
    logic       q_bout[$];
    logic [W:0] held;

    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", Diff, 0);
    check("rst_bout", Bout, 0);

    // Directed cases with out_ready held high: one-cycle result pulse.
    out_ready = 1'b1;
    accept(9, 3, 0);
    check("run_in_ready_low", in_ready, 0);
    wait_result("t9m3", 9, 3, 0);
    check("t9m3_literal", Diff, 5'b00110);
    tick();
    check("pulse_one_cycle", out_valid, 0);
    check("pulse_back_idle", in_ready, 1);
    check("hold_after_done", Diff, 5'b00110);

    accept(3, 9, 0);
    wait_result("t3m9", 3, 9, 0);
    check("t3m9_literal", Diff, 5'b11010);
    accept(0, 0, 1);
    wait_result("t0m0b", 0, 0, 1);
    check("t0m0b_literal", Diff, 5'b11111);
    accept(15, 15, 0);
    wait_result("t15m15", 15, 15, 0);
    check("t15m15_literal", Diff, 0);
    for (int i = 0; i < 6; i++) begin
      int ra, rb, rc;
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      rc = $urandom_range(0, 1);
      accept(ra, rb, rc);
      wait_result("rand", ra, rb, rc);
    end
    tick();

    // Backpressure: result held, new operands refused.
    out_ready = 1'b0;
    accept(3, 9, 0);
    wait_result("bp", 3, 9, 0);
    held = Diff;
    in_valid = 1'b1;
    A = 4'd1;
    B = 4'd1;
    Bin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_diff_stable", Diff, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    accept(1, 1, 0);
    wait_result("bp_next", 1, 1, 0);
    check("bp_next_literal", Diff, 0);

    // Reset abandons an operation in flight.
    accept(12, 5, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_ready", in_ready, 1);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen_valid++;
      tick();
    end
    check("midrun_no_output", seen_valid, 0);
    accept(12, 5, 0);
    wait_result("after_rst", 12, 5, 0);
    check("after_rst_literal", Diff, 5'b00111);
    tick();

    // Reset wins over a simultaneous in_valid.
    A = 4'd7;
    B = 4'd2;
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_ready", in_ready, 1);
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen_valid++;
      tick();
    end
    check("rst_vs_valid_dropped", seen_valid, 0);

    // Exhaustive sweep with random producer and consumer stalls.
    sent = 0;
    got = 0;
    cyc = 0;
    while ((sent < 512 || got < 512) && cyc < 40000) begin
      code = sent[8:0];
      in_valid = (sent < 512) && ($urandom_range(0, 3) != 0);
      A = code[8:5];
      B = code[4:1];
      Bin = code[0];
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        q_diff.push_back(ref_diff(int'(code[8:5]), int'(code[4:1]), int'(code[0])));
        q_bout.push_back(ref_bout(int'(code[8:5]), int'(code[4:1]), int'(code[0])));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q_diff.size() > 0) begin
          check("exh_diff", Diff, q_diff.pop_front());
          check("exh_bout", Bout, q_bout.pop_front());
        end else begin
          check("exh_spurious", 1, 0);
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("exh_sent", sent, 512);
    check("exh_count", got, sent);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
